// File: rtl/wrr_pkg.sv
// ----------------------------------------------------------------------------
// wrr_pkg : shared helpers for the weighted round-robin handshake arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package wrr_pkg;

  // Index width that stays at least one bit wide for tiny requester counts
  function automatic int addr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int default_weight(input int idx, input int wd);
    int max_w;
    max_w = (1 << wd) - 1;
    return (idx + 1 > max_w) ? max_w : idx + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_prio_pick.sv
// ----------------------------------------------------------------------------
// rr_prio_pick : first set bit of vec at or above ptr, wrapping to bit 0
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_prio_pick
  import wrr_pkg::*;
#(
  parameter  int REQ_NUM = 8,
  localparam int ADDR_WD = addr_width(REQ_NUM)
) (
  input  logic [REQ_NUM-1:0] vec,
  input  logic [ADDR_WD-1:0] ptr,
  output logic [REQ_NUM-1:0] onehot,
  output logic [ADDR_WD-1:0] idx,
  output logic               any
);

  logic [REQ_NUM-1:0]   ge_mask;
  logic [2*REQ_NUM-1:0] dbl;
  logic [2*REQ_NUM-1:0] lowbit;

  // Low half holds only bits at/after ptr; high half is the wrapped copy
  always_comb begin
    ge_mask = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      ge_mask[i] = (i >= int'(ptr));
    end
    dbl    = {vec, vec & ge_mask};
    lowbit = dbl & (~dbl + (2*REQ_NUM)'(1));
    onehot = lowbit[REQ_NUM-1:0] | lowbit[2*REQ_NUM-1:REQ_NUM];
    idx    = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (onehot[i]) idx = idx | ADDR_WD'(i);
    end
    any = |vec;
  end

endmodule

`default_nettype wire

// File: rtl/wrr_hs_arbiter.sv
// ----------------------------------------------------------------------------
// wrr_hs_arbiter : weighted round-robin arbiter, programmable weights,
//                  valid/ready grant with lock under back-pressure
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module wrr_hs_arbiter
  import wrr_pkg::*;
#(
  parameter  int REQ_NUM   = 8,
  parameter  int WEIGHT_WD = 4,
  localparam int ADDR_WD   = addr_width(REQ_NUM)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [REQ_NUM-1:0]           reqs,
  input  logic                         cfg_load,
  input  logic [REQ_NUM*WEIGHT_WD-1:0] cfg_weights,
  output logic                         gnt_valid,
  input  logic                         gnt_ready,
  output logic [REQ_NUM-1:0]           grants,
  output logic [ADDR_WD-1:0]           gnt_idx
);

  logic [REQ_NUM-1:0][WEIGHT_WD-1:0] weight_q, weight_d;
  logic [REQ_NUM-1:0][WEIGHT_WD-1:0] credit_q, credit_d;
  logic [ADDR_WD-1:0]                ptr_q, ptr_d;
  logic [ADDR_WD-1:0]                lock_idx_q, lock_idx_d;
  logic                              lock_q, lock_d;

  logic [REQ_NUM-1:0] active;
  logic [REQ_NUM-1:0] has_credit;
  logic [REQ_NUM-1:0] cand;
  logic               refill;
  logic               handshake;
  logic [REQ_NUM-1:0] pick_onehot;
  logic [ADDR_WD-1:0] pick_idx;
  logic               pick_any;

  // Refill is suppressed while locked so a held grant never restarts the epoch
  always_comb begin
    active     = '0;
    has_credit = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      active[i]     = reqs[i] & (weight_q[i] != '0);
      has_credit[i] = active[i] & (credit_q[i] != '0);
    end
    refill = !lock_q && (active != '0) && (has_credit == '0);
    cand   = refill ? active : has_credit;
  end

  rr_prio_pick #(
    .REQ_NUM (REQ_NUM)
  ) u_pick (
    .vec    (cand),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    if (lock_q) begin
      gnt_valid = 1'b1;
      grants    = {{(REQ_NUM-1){1'b0}}, 1'b1} << lock_idx_q;
      gnt_idx   = lock_idx_q;
    end else begin
      gnt_valid = pick_any;
      grants    = pick_onehot;
      gnt_idx   = pick_idx;
    end
  end

  assign handshake = gnt_valid && gnt_ready;

  always_comb begin
    weight_d   = weight_q;
    credit_d   = refill ? weight_q : credit_q;
    ptr_d      = ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (gnt_valid && !gnt_ready) begin
      lock_d     = 1'b1;
      lock_idx_d = gnt_idx;
    end
    if (handshake) begin
      // Saturate: a locked requester zeroed by cfg_load may complete at 0
      if (credit_d[gnt_idx] != '0) begin
        credit_d[gnt_idx] = credit_d[gnt_idx] - WEIGHT_WD'(1);
      end
      ptr_d  = (gnt_idx == ADDR_WD'(REQ_NUM-1)) ? '0 : gnt_idx + ADDR_WD'(1);
      lock_d = 1'b0;
    end
    if (cfg_load) begin
      weight_d = cfg_weights;
      credit_d = cfg_weights;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REQ_NUM; i++) begin
        weight_q[i] <= WEIGHT_WD'(default_weight(i, WEIGHT_WD));
        credit_q[i] <= WEIGHT_WD'(default_weight(i, WEIGHT_WD));
      end
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      weight_q   <= weight_d;
      credit_q   <= credit_d;
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

endmodule

`default_nettype wire
